// File: rtl/nn_fixed_pkg.sv
// Shared Q1.16 fixed-point constants, saturation helper and FSM states for the neuron_13in family.
package nn_fixed_pkg;

    localparam int unsigned DW   = 17;
    localparam int unsigned N_IN = 13;

    localparam logic [DW-1:0]      ONE     = 17'h10000;
    localparam logic signed [18:0] SAT_MAX = 19'sd65535;
    localparam logic signed [18:0] SAT_MIN = -19'sd65536;

    typedef enum logic [2:0] {
        StIdle,
        StDeriv,
        StDelta,
        StStep,
        StUpd,
        StBias,
        StDone
    } state_e;

    // Clamp a widened sum back into the signed 17-bit weight range.
    function automatic logic [DW-1:0] sat17(input logic signed [18:0] v);
        if (v > SAT_MAX) begin
            return 17'h0FFFF;
        end else if (v < SAT_MIN) begin
            return 17'h10000;
        end else begin
            return v[DW-1:0];
        end
    endfunction

endpackage

// File: rtl/neuron_13in_backprop_if.sv
// Request/response bundle for the 13-input neuron backprop block.
interface neuron_13in_backprop_if;
    import nn_fixed_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [DW-1:0]         y;
    logic [DW-1:0]         t;
    logic [DW-1:0]         eta;
    logic [DW*N_IN-1:0]    x;
    logic [DW*N_IN-1:0]    w;
    logic [DW-1:0]         bias;
    logic [DW*N_IN-1:0]    w_out;
    logic [DW-1:0]         bias_out;
    logic [17:0]           delta_out;
    logic                  out_valid;
    logic                  done;

    modport master (
        output in_valid, y, t, eta, x, w, bias,
        input  in_ready, w_out, bias_out, delta_out, out_valid, done
    );

    modport slave (
        input  in_valid, y, t, eta, x, w, bias,
        output in_ready, w_out, bias_out, delta_out, out_valid, done
    );

endinterface

// File: rtl/nn_mul18.sv
// Combinational signed 18x18 multiplier shared by every backprop stage.
module nn_mul18 (
    input  logic signed [17:0] a_i,
    input  logic signed [17:0] b_i,
    output logic signed [35:0] p_o
);

    assign p_o = a_i * b_i;

endmodule

// File: rtl/neuron_13in_backprop.sv
// Serial backward pass for a 13-input sigmoid neuron: derivative, delta, step, then one
// weight update per cycle through a single shared multiplier, followed by the bias update.
module neuron_13in_backprop
    import nn_fixed_pkg::*;
#(
    parameter int unsigned LrSh = 20
) (
    input logic                    clk,
    input logic                    rst_n,
    neuron_13in_backprop_if.slave  bus
);

    state_e state_q, state_d;

    logic [3:0]             idx_q;
    logic [DW-1:0]          y_q, t_q, eta_q, bias_q;
    logic [DW-1:0]          x_q [N_IN];
    logic [DW-1:0]          w_q [N_IN];
    logic signed [17:0]     err_q;
    logic [DW-1:0]          deriv_q;
    logic signed [17:0]     delta_q;
    logic signed [17:0]     step_q;
    logic [DW*N_IN-1:0]     w_out_q;
    logic [DW-1:0]          bias_out_q;
    logic                   out_valid_q;

    logic signed [17:0]     mul_a, mul_b;
    logic signed [35:0]     prod;
    logic signed [35:0]     step_full;
    logic signed [17:0]     dw;
    logic [DW-1:0]          one_minus_y;
    logic [DW-1:0]          w_cur;
    logic signed [18:0]     w_sum, b_sum;
    logic                   unused_bits;

    // Out-of-range y (above 1.0) flattens the derivative to zero.
    assign one_minus_y = (y_q > ONE) ? '0 : ONE - y_q;
    assign w_cur       = w_q[idx_q];

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        unique case (state_q)
            StDeriv: begin
                mul_a = $signed({1'b0, y_q});
                mul_b = $signed({1'b0, one_minus_y});
            end
            StDelta: begin
                mul_a = err_q;
                mul_b = $signed({1'b0, deriv_q});
            end
            StStep: begin
                mul_a = $signed({1'b0, eta_q});
                mul_b = delta_q;
            end
            StUpd: begin
                mul_a = step_q;
                mul_b = $signed({1'b0, x_q[idx_q]});
            end
            default: ;
        endcase
    end

    nn_mul18 u_mul (
        .a_i (mul_a),
        .b_i (mul_b),
        .p_o (prod)
    );

    assign step_full   = prod >>> LrSh;
    assign dw          = prod[33:16];
    assign w_sum       = $signed({{2{w_cur[DW-1]}}, w_cur}) + $signed({dw[17], dw});
    assign b_sum       = $signed({{2{bias_q[DW-1]}}, bias_q}) + $signed({step_q[17], step_q});
    assign unused_bits = ^{prod[15:0], step_full[35:18]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.in_valid) state_d = StDeriv;
            StDeriv: state_d = StDelta;
            StDelta: state_d = StStep;
            StStep:  state_d = StUpd;
            StUpd:   if (idx_q == 4'(N_IN - 1)) state_d = StBias;
            StBias:  state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.in_ready = (state_q == StIdle);
        bus.done     = (state_q == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            y_q         <= '0;
            t_q         <= '0;
            eta_q       <= '0;
            bias_q      <= '0;
            err_q       <= '0;
            deriv_q     <= '0;
            delta_q     <= '0;
            step_q      <= '0;
            w_out_q     <= '0;
            bias_out_q  <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < N_IN; i++) begin
                x_q[i] <= '0;
                w_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        y_q         <= bus.y;
                        t_q         <= bus.t;
                        eta_q       <= bus.eta;
                        bias_q      <= bus.bias;
                        idx_q       <= '0;
                        out_valid_q <= 1'b0;
                        for (int i = 0; i < N_IN; i++) begin
                            x_q[i] <= bus.x[i*DW +: DW];
                            w_q[i] <= bus.w[i*DW +: DW];
                        end
                    end
                end
                StDeriv: begin
                    err_q   <= $signed({1'b0, t_q}) - $signed({1'b0, y_q});
                    deriv_q <= prod[32:16];
                end
                StDelta: delta_q <= prod[33:16];
                StStep:  step_q  <= step_full[17:0];
                StUpd: begin
                    w_q[idx_q] <= sat17(w_sum);
                    idx_q      <= idx_q + 4'd1;
                end
                StBias: begin
                    bias_out_q  <= sat17(b_sum);
                    out_valid_q <= 1'b1;
                    for (int i = 0; i < N_IN; i++) begin
                        w_out_q[i*DW +: DW] <= w_q[i];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.w_out     = w_out_q;
    assign bus.bias_out  = bias_out_q;
    assign bus.delta_out = delta_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_neuron_13in_backprop.sv
// Directed-vector bench for neuron_13in_backprop: table of hand-computed updates plus
// reset-abort, busy-ignore and back-to-back sequences.
module tb_neuron_13in_backprop;
    import nn_fixed_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    neuron_13in_backprop_if bus ();

    neuron_13in_backprop dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [16:0] y, t, eta, x0, xo, w0, wo, bias;
        logic [16:0] e_w0, e_wo, e_bias;
        logic [17:0] e_delta;
    } vec_t;

    vec_t vecs [9];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.y    = v.y;
        bus.t    = v.t;
        bus.eta  = v.eta;
        bus.bias = v.bias;
        for (int i = 0; i < N_IN; i++) begin
            bus.x[i*DW +: DW] = (i == 0) ? v.x0 : v.xo;
            bus.w[i*DW +: DW] = (i == 0) ? v.w0 : v.wo;
        end
    endtask

    // Present a request for one cycle; returns at the negedge of cycle T+1.
    task automatic start(input vec_t v);
        drive(v);
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic check_results(input vec_t v, input string name);
        check({name, "/w0"}, 64'(bus.w_out[DW-1:0]), 64'(v.e_w0));
        for (int i = 1; i < N_IN; i++) begin
            check({name, $sformatf("/w%0d", i)}, 64'(bus.w_out[i*DW +: DW]), 64'(v.e_wo));
        end
        check({name, "/bias"}, 64'(bus.bias_out), 64'(v.e_bias));
        check({name, "/delta"}, 64'(bus.delta_out), 64'(v.e_delta));
        check({name, "/out_valid"}, 64'(bus.out_valid), 64'd1);
    endtask

    // Wait from cycle c0 for done; returns the cycle index (0 on timeout).
    task automatic wait_done(input int c0, output int lat);
        lat = 0;
        for (int c = c0; c <= 40; c++) begin
            if (bus.done) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int lat;
        start(v);
        check({name, "/busy_flags"}, 64'({bus.in_ready, bus.out_valid}), 64'd0);
        wait_done(1, lat);
        check({name, "/latency"}, 64'(lat), 64'd18);
        check_results(v, name);
        @(negedge clk);
        check({name, "/after_done"}, 64'({bus.done, bus.in_ready, bus.out_valid}), 64'b011);
    endtask

    initial begin
        int lat, ndone, d1, d2;

        //           y         t         eta       x0        xo        w0        wo        bias
        //           e_w0      e_wo      e_bias    e_delta
        vecs[0] = '{17'h08000, 17'h08000, 17'h10000, 17'h10000, 17'h10000, 17'h01000, 17'h01000, 17'h0,
                    17'h01000, 17'h01000, 17'h0, 18'h0};
        vecs[1] = '{17'h08000, 17'h10000, 17'h10000, 17'h10000, 17'h0, 17'h01000, 17'h01000, 17'h0,
                    17'h01200, 17'h01000, 17'h00200, 18'h02000};
        vecs[2] = '{17'h08000, 17'h10000, 17'h10000, 17'h10000, 17'h0, 17'h0FFFF, 17'h01000, 17'h0,
                    17'h0FFFF, 17'h01000, 17'h00200, 18'h02000};
        vecs[3] = '{17'h08000, 17'h0, 17'h10000, 17'h10000, 17'h0, 17'h10000, 17'h01000, 17'h0,
                    17'h10000, 17'h01000, 17'h1FE00, 18'h3E000};
        vecs[4] = '{17'h0, 17'h10000, 17'h10000, 17'h10000, 17'h10000, 17'h01000, 17'h1FF00, 17'h01234,
                    17'h01000, 17'h1FF00, 17'h01234, 18'h0};
        vecs[5] = '{17'h10000, 17'h0, 17'h10000, 17'h10000, 17'h10000, 17'h01000, 17'h1FF00, 17'h01234,
                    17'h01000, 17'h1FF00, 17'h01234, 18'h0};
        vecs[6] = '{17'h18000, 17'h0, 17'h10000, 17'h10000, 17'h10000, 17'h01000, 17'h1FF00, 17'h01234,
                    17'h01000, 17'h1FF00, 17'h01234, 18'h0};
        vecs[7] = '{17'h04000, 17'h10000, 17'h08000, 17'h08000, 17'h04000, 17'h00100, 17'h1FF00, 17'h00010,
                    17'h00190, 17'h1FF48, 17'h00130, 18'h02400};
        vecs[8] = '{17'h0C000, 17'h04000, 17'h10000, 17'h10000, 17'h00001, 17'h0, 17'h00005, 17'h0,
                    17'h1FE80, 17'h00004, 17'h1FE80, 18'h3E800};

        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        drive(vecs[0]);
        repeat (3) @(negedge clk);
        check("reset/ready_done_valid", 64'({bus.in_ready, bus.done, bus.out_valid}), 64'b100);
        check("reset/w_out", 64'(|bus.w_out), 64'd0);
        check("reset/bias_delta", 64'({bus.bias_out, bus.delta_out}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 9; k++) begin
            run_vec(vecs[k], $sformatf("vec%0d", k));
        end

        // Reset asserted in the middle of the weight sweep aborts the transaction.
        start(vecs[1]);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst/ready_done_valid", 64'({bus.in_ready, bus.done, bus.out_valid}), 64'b100);
        check("midrst/w_out", 64'(|bus.w_out), 64'd0);
        check("midrst/bias_delta", 64'({bus.bias_out, bus.delta_out}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("midrst/no_done", 64'(ndone), 64'd0);
        check("midrst/ready", 64'(bus.in_ready), 64'd1);
        run_vec(vecs[1], "midrst/next");

        // A pulse on in_valid while busy is dropped and the captured operands are kept.
        start(vecs[1]);
        repeat (4) @(negedge clk);
        drive(vecs[4]);
        bus.in_valid = 1'b1;
        check("busy/ready_low", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_done(6, lat);
        check("busy/latency", 64'(lat), 64'd18);
        check_results(vecs[1], "busy");
        ndone = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("busy/no_second_done", 64'(ndone), 64'd0);

        // in_valid held high: back-to-back accepts 19 cycles apart.
        drive(vecs[1]);
        bus.in_valid = 1'b1;
        @(negedge clk);
        check("held/ready_low", 64'(bus.in_ready), 64'd0);
        ndone = 0;
        d1    = 0;
        d2    = 0;
        for (int c = 1; c <= 45; c++) begin
            if (bus.done) begin
                ndone++;
                if (ndone == 1) d1 = c;
                if (ndone == 2) begin
                    d2 = c;
                    check_results(vecs[1], "held/second");
                end
            end
            if (c == 20) bus.in_valid = 1'b0;
            @(negedge clk);
        end
        check("held/done_count", 64'(ndone), 64'd2);
        check("held/first_done", 64'(d1), 64'd18);
        check("held/second_done", 64'(d2), 64'd37);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
